// File: rtl/bw_mult_seq.sv
// Sequential Baugh-Wooley multiplier: accumulates RPC partial-product rows per clock.
// Optional macro APX_TRUNC_EN zeroes all partial-product bits in columns below TRUNC_COL.
module bw_mult_seq #(
    parameter int DW        = 12,
    parameter int RPC       = 3,
    parameter int TRUNC_COL = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [DW-1:0]   i_muld,
    input  logic [DW-1:0]   i_mulr,
    input  logic            i_signed_mode,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [2*DW-1:0] o_prod,
    output logic            o_busy
);

    localparam int PW = 2 * DW;
    localparam int IW = $clog2(DW);
    localparam int CW = $clog2(DW + 1);
    localparam logic [PW-1:0] K_SIGNED   = (PW'(1) << DW) | (PW'(1) << (PW - 1));
    localparam logic [PW-1:0] TRUNC_MASK = ~((PW'(1) << TRUNC_COL) - PW'(1));

    if (DW < 4 || (DW % RPC) != 0 || TRUNC_COL < 0 || TRUNC_COL > DW) begin : g_bad_params
        $error("bw_mult_seq: illegal parameters DW=%0d RPC=%0d TRUNC_COL=%0d", DW, RPC, TRUNC_COL);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_muld;
    logic [DW-1:0]   r_mulr;
    logic            r_signed;
    logic [PW-1:0]   w_sum;
    logic            w_accept;
    logic            w_last_row_group;

    // Row idx with the Baugh-Wooley sign-bit inversions; K in the accumulator balances them.
    function automatic logic [PW-1:0] rowGen(input logic [IW-1:0] idx);
        logic [DW-1:0] pp;
        logic [PW-1:0] row;
        pp = r_muld & {DW{r_mulr[idx]}};
        if (r_signed) begin
            if (idx == IW'(DW - 1)) begin
                pp[DW-2:0] = ~pp[DW-2:0];
            end else begin
                pp[DW-1] = ~pp[DW-1];
            end
        end
        row = PW'(pp) << idx;
`ifdef APX_TRUNC_EN
        row = row & TRUNC_MASK;
`endif
        return row;
    endfunction

    always_comb begin
        w_sum = r_acc;
        for (int j = 0; j < RPC; j++) begin
            w_sum = w_sum + rowGen(IW'(r_cnt) + IW'(j));
        end
    end

    assign w_last_row_group = (r_cnt == CW'(DW - RPC));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_busy       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = ~i_rst;
                w_accept   = i_in_valid & ~i_rst;
                if (w_accept) begin
                    w_state_next = ACC;
                end
            end
            ACC: begin
                o_busy = 1'b1;
                if (w_last_row_group) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_muld   <= '0;
            r_mulr   <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_muld   <= i_muld;
            r_mulr   <= i_mulr;
            r_signed <= i_signed_mode;
            r_cnt    <= '0;
            r_acc    <= i_signed_mode ? K_SIGNED : '0;
        end else if (r_state == ACC) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(RPC);
        end
    end

    assign o_prod = r_acc;

endmodule

// File: tb/tb_bw_mult_seq.sv
// Directed self-checking bench for bw_mult_seq (DW=12, RPC=3) with hand-computed products.
module tb_bw_mult_seq;

    localparam int DW = 12;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic          outReady;
    logic          signedMode;
    logic [DW-1:0] muld;
    logic [DW-1:0] mulr;
    logic          inReady;
    logic          outValid;
    logic          busy;
    logic [PW-1:0] prod;

    int nVec  = 0;
    int nMiss = 0;

    always #5 clk = ~clk;

    bw_mult_seq #(.DW(DW), .RPC(3), .TRUNC_COL(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (inValid),
        .o_in_ready    (inReady),
        .i_muld        (muld),
        .i_mulr        (mulr),
        .i_signed_mode (signedMode),
        .o_out_valid   (outValid),
        .i_out_ready   (outReady),
        .o_prod        (prod),
        .o_busy        (busy)
    );

    task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge, then scramble inputs to prove they are not resampled.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sm);
        @(negedge clk);
        checkOutput("in_ready_idle", PW'(inReady), PW'(1));
        inValid    = 1'b1;
        muld       = a;
        mulr       = b;
        signedMode = sm;
        @(posedge clk);
        #1;
        inValid    = 1'b0;
        muld       = ~a;
        mulr       = ~b;
        signedMode = ~sm;
    endtask

    task automatic waitResult(input string tag);
        int edges = 1;
        checkOutput({tag, "_busy_acc"}, PW'(busy), PW'(1));
        while (outValid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, "_latency"}, PW'(edges), PW'(5));
    endtask

    task automatic checkProd(input string tag, input logic [PW-1:0] exp);
`ifdef APX_TRUNC_EN
        checkOutput({tag, "_lowcols"}, prod & PW'(8'hFF), PW'(0));
`else
        checkOutput(tag, prod, exp);
`endif
    endtask

    task automatic releaseResult(input string tag);
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput({tag, "_valid_drop"}, PW'(outValid), PW'(0));
        checkOutput({tag, "_ready_back"}, PW'(inReady), PW'(1));
    endtask

    task automatic runOp(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sm, input logic [PW-1:0] exp);
        applyStimulus(a, b, sm);
        waitResult(tag);
        checkProd(tag, exp);
        releaseResult(tag);
    endtask

    initial begin
        logic [PW-1:0] held;
        rst        = 1'b1;
        inValid    = 1'b0;
        outReady   = 1'b0;
        signedMode = 1'b0;
        muld       = '0;
        mulr       = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", PW'(inReady), PW'(0));
        checkOutput("rst_out_valid", PW'(outValid), PW'(0));
        checkOutput("rst_busy", PW'(busy), PW'(0));
        checkOutput("rst_prod", prod, PW'(0));
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", PW'(inReady), PW'(1));

        runOp("u_max", 12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
        runOp("s_minmin", 12'h800, 12'h800, 1'b1, 24'h400000);
        runOp("s_neg1x5", 12'hFFF, 12'h005, 1'b1, 24'hFFFFFB);
        runOp("s_maxmax", 12'h7FF, 12'h7FF, 1'b1, 24'h3FF001);
        runOp("s_minmax", 12'h800, 12'h7FF, 1'b1, 24'hC00800);
        runOp("u_fffx1", 12'hFFF, 12'h001, 1'b0, 24'h000FFF);
        runOp("s_fffx1", 12'hFFF, 12'h001, 1'b1, 24'hFFFFFF);

        applyStimulus(12'h0FF, 12'h0FF, 1'b0);
        waitResult("trunc");
`ifdef APX_TRUNC_EN
        checkOutput("trunc_prod", prod, 24'h00F700);
`else
        checkOutput("trunc_prod", prod, 24'h00FE01);
`endif
        releaseResult("trunc");

        // Backpressure: result must hold while out_ready stays low, and new requests are ignored.
        applyStimulus(12'h123, 12'h456, 1'b0);
        waitResult("bp");
        checkProd("bp_prod", 24'h04EDC2);
        held = prod;
        inValid = 1'b1;
        muld    = 12'h001;
        mulr    = 12'h001;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_prod_stable", prod, held);
            checkOutput("bp_valid_held", PW'(outValid), PW'(1));
        end
        checkOutput("bp_in_ready", PW'(inReady), PW'(0));
        checkOutput("bp_busy", PW'(busy), PW'(1));
        inValid = 1'b0;
        releaseResult("bp");
        checkOutput("bp_idle_busy", PW'(busy), PW'(0));

        // Reset during the second ACC cycle aborts the operation.
        applyStimulus(12'h123, 12'h456, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstacc_ready_low", PW'(inReady), PW'(0));
        @(posedge clk);
        #1;
        checkOutput("rstacc_valid", PW'(outValid), PW'(0));
        checkOutput("rstacc_busy", PW'(busy), PW'(0));
        checkOutput("rstacc_prod", prod, PW'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstacc_ready_back", PW'(inReady), PW'(1));
        runOp("u_3x7", 12'h003, 12'h007, 1'b0, 24'h000015);

        // Reset beats a simultaneous out_valid/out_ready transfer in DONE.
        applyStimulus(12'h00A, 12'h00B, 1'b0);
        waitResult("rstdone");
        @(negedge clk);
        rst      = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstdone_valid", PW'(outValid), PW'(0));
        checkOutput("rstdone_prod", prod, PW'(0));
        @(negedge clk);
        rst      = 1'b0;
        outReady = 1'b0;
        #1;
        checkOutput("rstdone_ready", PW'(inReady), PW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
